// File: rtl/h_sched.sv
// rtl/h_sched.sv - in-order command queue with key-hazard interlock in front of the hash-table body
package h_pkg;
    typedef enum logic [1:0] {
        OP_NOP = 2'd0,
        OP_QRY = 2'd1,
        OP_INS = 2'd2,
        OP_DEL = 2'd3
    } opcode_t;
    typedef logic [7:0]  k_t;
    typedef logic [15:0] v_t;
endpackage

module h_sched #(
    parameter int Q_N = 4,
    parameter int LAT = 4
) (
    input  logic           clk,
    input  logic           arst_n,
    input  logic           cmd_vld,
    output logic           cmd_rdy,
    input  h_pkg::opcode_t cmd_opcode,
    input  h_pkg::k_t      cmd_k,
    input  h_pkg::v_t      cmd_v,
    output logic           iss_vld,
    output h_pkg::opcode_t iss_opcode,
    output h_pkg::k_t      iss_k,
    output h_pkg::v_t      iss_v,
    input  logic           bdy_rsp_vld,
    output logic           busy,
    output logic           err,
    output logic [15:0]    stall_cnt
);
    import h_pkg::*;

    localparam int AW = $clog2(Q_N);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wr_ptr, rd_ptr;
    opcode_t     q_op [Q_N];
    k_t          q_k  [Q_N];
    v_t          q_v  [Q_N];

    logic        empty, full, head_vld, head_wr, hazard, enq, issue;
    opcode_t     head_op;
    k_t          head_k;
    v_t          head_v;

    logic [LAT-1:0] s_vld, s_wr;
    k_t             s_k [LAT];

    // The extra pointer bit separates a full queue from an empty one.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign cmd_rdy  = !full;
    assign head_vld = !empty;
    assign head_op  = q_op[rd_ptr[AW-1:0]];
    assign head_k   = q_k[rd_ptr[AW-1:0]];
    assign head_v   = q_v[rd_ptr[AW-1:0]];
    assign head_wr  = (head_op != OP_QRY);

    // NOPs are acknowledged on the handshake but never occupy a slot.
    assign enq   = cmd_vld && !full && (cmd_opcode != OP_NOP);
    assign issue = head_vld && !hazard;

    // Includes the stage completing this cycle; read-after-read is harmless.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            if (s_vld[i] && (s_k[i] == head_k) && (s_wr[i] || head_wr))
                hazard = 1'b1;
        end
    end

    assign iss_vld    = issue;
    assign iss_opcode = issue ? head_op : OP_NOP;
    assign iss_k      = issue ? head_k  : '0;
    assign iss_v      = issue ? head_v  : '0;
    assign busy       = !empty || (|s_vld);

    always_ff @(posedge clk) begin
        if (enq) begin
            q_op[wr_ptr[AW-1:0]] <= cmd_opcode;
            q_k[wr_ptr[AW-1:0]]  <= cmd_k;
            q_v[wr_ptr[AW-1:0]]  <= cmd_v;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            s_vld     <= '0;
            s_wr      <= '0;
            for (int i = 0; i < LAT; i++) s_k[i] <= '0;
            err       <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (enq)   wr_ptr <= wr_ptr + PTR_ONE;
            if (issue) rd_ptr <= rd_ptr + PTR_ONE;

            s_vld[0] <= issue;
            s_wr[0]  <= head_wr;
            s_k[0]   <= head_k;
            for (int i = 1; i < LAT; i++) begin
                s_vld[i] <= s_vld[i-1];
                s_wr[i]  <= s_wr[i-1];
                s_k[i]   <= s_k[i-1];
            end

            if (bdy_rsp_vld != s_vld[LAT-1]) err <= 1'b1;
            if (head_vld && hazard && (stall_cnt != 16'hFFFF))
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule
